// File: rtl/zeta_stream_gen.sv
// Twiddle-factor stream generator for an NTT/INTT butterfly unit.
// Each zeta = ROOT_OF_UNITY^brv(k) mod Q is computed on the fly by K square-and-multiply steps.
module zeta_stream_gen #(
    parameter int unsigned ROOT_OF_UNITY = 17,
    parameter int unsigned Q             = 3329,
    parameter int unsigned K             = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          inverse,
    output logic          busy,
    output logic          zeta_valid,
    input  logic          zeta_ready,
    output logic [15:0]   zeta,
    output logic [K-1:0]  zeta_idx,
    output logic          last,
    output logic          done
);

    localparam int unsigned QW = $clog2(Q);
    localparam int unsigned PW = 2 * QW + 5;
    localparam int unsigned BW = (K > 1) ? $clog2(K) : 1;
    localparam logic [BW-1:0] BitTop = BW'(K - 1);
    localparam logic [K-1:0]  IdxMax = '1;

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

    state_e        state_q, state_d;
    logic [QW-1:0] acc_q, acc_d;
    logic [K-1:0]  k_q, k_d;
    logic [BW-1:0] bitpos_q, bitpos_d;
    logic          inv_q, inv_d;
    logic          done_q, done_d;

    logic [K-1:0]  exp_brv;
    logic [PW-1:0] sq, mul;
    logic [QW-1:0] t, step;
    logic          is_last;

    // Exponent is the bit-reversed index; walked MSB first via bitpos.
    always_comb begin
        for (int i = 0; i < int'(K); i++) begin
            exp_brv[i] = k_q[int'(K) - 1 - i];
        end
    end

    always_comb begin
        sq   = PW'(acc_q) * PW'(acc_q);
        t    = QW'(sq % PW'(Q));
        mul  = PW'(t) * PW'(ROOT_OF_UNITY);
        step = exp_brv[bitpos_q] ? QW'(mul % PW'(Q)) : t;
    end

    assign is_last = inv_q ? (k_q == '0) : (k_q == IdxMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            acc_q    <= QW'(1);
            k_q      <= '0;
            bitpos_q <= '0;
            inv_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            bitpos_q <= bitpos_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        k_d      = k_q;
        bitpos_d = bitpos_q;
        inv_d    = inv_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    inv_d    = inverse;
                    k_d      = inverse ? IdxMax : '0;
                    acc_d    = QW'(1);
                    bitpos_d = BitTop;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                acc_d    = step;
                bitpos_d = bitpos_q - BW'(1);
                if (bitpos_q == '0) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                if (zeta_ready) begin
                    if (is_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        k_d      = inv_q ? (k_q - K'(1)) : (k_q + K'(1));
                        acc_d    = QW'(1);
                        bitpos_d = BitTop;
                        state_d  = StCalc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        zeta_valid = (state_q == StOut);
        last       = zeta_valid & is_last;
        done       = done_q;
        zeta_idx   = k_q;
        zeta       = '0;
        if (zeta_valid) begin
            // Inverse stream emits the additive negation; acc is never zero.
            zeta = inv_q ? (16'(Q) - 16'(acc_q)) : 16'(acc_q);
        end
    end

endmodule

// File: tb/tb_zeta_stream_gen.sv
// Directed, table-driven bench for zeta_stream_gen: full streams in both modes, backpressure,
// ignored start while busy, mid-stream reset and back-to-back start in the done cycle.
module tb_zeta_stream_gen;

    localparam int K    = 7;
    localparam int Q    = 3329;
    localparam int ROOT = 17;
    localparam int N    = 1 << K;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         inverse;
    logic         busy;
    logic         zeta_valid;
    logic         zeta_ready;
    logic [15:0]  zeta;
    logic [K-1:0] zeta_idx;
    logic         last;
    logic         done;

    always #5 clk = ~clk;

    zeta_stream_gen #(
        .ROOT_OF_UNITY(ROOT),
        .Q            (Q),
        .K            (K)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inverse   (inverse),
        .busy      (busy),
        .zeta_valid(zeta_valid),
        .zeta_ready(zeta_ready),
        .zeta      (zeta),
        .zeta_idx  (zeta_idx),
        .last      (last),
        .done      (done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Reference: plain repeated multiplication, independent of square-and-multiply.
    function automatic int model_z(input int k, input bit inv);
        int e = 0;
        int z = 1;
        for (int i = 0; i < K; i++) begin
            if (((k >> i) & 1) == 1) e = e | (1 << (K - 1 - i));
        end
        for (int j = 0; j < e; j++) z = (z * ROOT) % Q;
        return inv ? (Q - z) : z;
    endfunction

    int cap_idx[N];
    int cap_z[N];
    int cap_last[N];
    int cap_n, first_e, done_e, last_hs_e;
    int fwd_idx[N], fwd_z[N], fwd_last[N];
    int inv_idx[N], inv_z[N], inv_last[N];

    // Called just after the edge that samples start; e counts edges since then.
    task automatic collect(input int glitch_e);
        int e;
        e         = 0;
        cap_n     = 0;
        first_e   = -1;
        done_e    = -1;
        last_hs_e = -1;
        while (e < 2000 && done_e < 0) begin
            @(negedge clk);
            if (e == 0) begin
                start   = 1'b0;
                inverse = 1'b0;
            end
            if (e == glitch_e) begin
                start   = 1'b1;
                inverse = 1'b1;
            end
            if (e == glitch_e + 1) begin
                start   = 1'b0;
                inverse = 1'b0;
            end
            if (zeta_valid && first_e < 0) first_e = e;
            if (zeta_valid && zeta_ready) begin
                if (cap_n < N) begin
                    cap_idx[cap_n]  = int'(zeta_idx);
                    cap_z[cap_n]    = int'(zeta);
                    cap_last[cap_n] = int'(last);
                end
                cap_n++;
                last_hs_e = e + 1;
            end
            if (done) done_e = e;
            if (done_e < 0) begin
                @(posedge clk);
                e++;
            end
        end
        if (done_e < 0) check("stream_timeout", 0, 1);
    endtask

    typedef struct {
        bit inv;
        int pos;
        int idx;
        int zeta;
        int last;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int snap_z, snap_idx, snap_last, bad, guard, seen5, next_idx;

        tbl[0] = '{1'b0, 0,   0,   1,    0};
        tbl[1] = '{1'b0, 1,   1,   1729, 0};
        tbl[2] = '{1'b0, 2,   2,   2580, 0};
        tbl[3] = '{1'b0, 3,   3,   3289, 0};
        tbl[4] = '{1'b0, 127, 127, -1,   1};
        tbl[5] = '{1'b1, 0,   127, -1,   0};
        tbl[6] = '{1'b1, 126, 1,   1600, 0};
        tbl[7] = '{1'b1, 127, 0,   3328, 1};

        rst        = 1'b1;
        start      = 1'b0;
        inverse    = 1'b0;
        zeta_ready = 1'b1;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(zeta_valid), 0);
        check("rst_last", int'(last), 0);
        check("rst_done", int'(done), 0);
        check("rst_zeta", int'(zeta), 0);
        check("rst_idx", int'(zeta_idx), 0);
        @(negedge clk);
        rst = 1'b0;

        // Forward stream, with a start/inverse pulse injected while busy.
        @(negedge clk);
        start   = 1'b1;
        inverse = 1'b0;
        @(posedge clk);
        collect(20);
        for (int i = 0; i < N; i++) begin
            fwd_idx[i]  = cap_idx[i];
            fwd_z[i]    = cap_z[i];
            fwd_last[i] = cap_last[i];
        end
        check("fwd_first_valid_edge", first_e, K);
        check("fwd_count", cap_n, N);
        check("fwd_done_edge", done_e, N * (K + 1));

        // Start the inverse stream in the done cycle.
        start   = 1'b1;
        inverse = 1'b1;
        @(posedge clk);
        collect(-1);
        for (int i = 0; i < N; i++) begin
            inv_idx[i]  = cap_idx[i];
            inv_z[i]    = cap_z[i];
            inv_last[i] = cap_last[i];
        end
        check("inv_first_valid_edge", first_e, K);
        check("inv_count", cap_n, N);
        check("inv_done_after_last", done_e, last_hs_e);
        check("inv_done_edge", done_e, N * (K + 1));

        for (int i = 0; i < 8; i++) begin
            int p;
            p = tbl[i].pos;
            if (tbl[i].inv) begin
                check($sformatf("tbl%0d_idx", i), inv_idx[p], tbl[i].idx);
                if (tbl[i].zeta >= 0) check($sformatf("tbl%0d_zeta", i), inv_z[p], tbl[i].zeta);
                check($sformatf("tbl%0d_last", i), inv_last[p], tbl[i].last);
            end else begin
                check($sformatf("tbl%0d_idx", i), fwd_idx[p], tbl[i].idx);
                if (tbl[i].zeta >= 0) check($sformatf("tbl%0d_zeta", i), fwd_z[p], tbl[i].zeta);
                check($sformatf("tbl%0d_last", i), fwd_last[p], tbl[i].last);
            end
        end

        for (int i = 0; i < N; i++) begin
            check($sformatf("fwd_idx[%0d]", i), fwd_idx[i], i);
            check($sformatf("fwd_zeta[%0d]", i), fwd_z[i], model_z(i, 1'b0));
            check($sformatf("fwd_last[%0d]", i), fwd_last[i], (i == N - 1) ? 1 : 0);
            check($sformatf("inv_idx[%0d]", i), inv_idx[i], N - 1 - i);
            check($sformatf("inv_zeta[%0d]", i), inv_z[i], model_z(N - 1 - i, 1'b1));
            check($sformatf("inv_last[%0d]", i), inv_last[i], (i == N - 1) ? 1 : 0);
        end

        // Backpressure at k=5.
        start   = 1'b1;
        inverse = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(zeta_valid && int'(zeta_idx) == 5) && guard < 200) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("bp_reach_k5", int'(zeta_valid && int'(zeta_idx) == 5), 1);
        zeta_ready = 1'b0;
        snap_z     = int'(zeta);
        snap_idx   = int'(zeta_idx);
        snap_last  = int'(last);
        bad        = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (!zeta_valid || int'(zeta) != snap_z || int'(zeta_idx) != snap_idx ||
                int'(last) != snap_last) bad++;
        end
        check("bp_stable", bad, 0);
        check("bp_zeta", snap_z, model_z(5, 1'b0));
        zeta_ready = 1'b1;
        seen5      = 0;
        next_idx   = -1;
        guard      = 0;
        while (next_idx < 0 && guard < 100) begin
            if (zeta_valid) begin
                if (int'(zeta_idx) == 5) seen5++;
                else next_idx = int'(zeta_idx);
            end
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("bp_k5_once", seen5, 1);
        check("bp_next_k6", next_idx, 6);

        // Reset in the middle of CALC for k=40.
        guard = 0;
        while (!(busy && !zeta_valid && int'(zeta_idx) == 40) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reach_k40", int'(busy && !zeta_valid && int'(zeta_idx) == 40), 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(zeta_valid), 0);
        check("mid_rst_last", int'(last), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_zeta", int'(zeta), 0);
        check("mid_rst_idx", int'(zeta_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || zeta_valid || done) bad++;
        end
        check("post_rst_quiet", bad, 0);
        start   = 1'b1;
        inverse = 1'b0;
        @(posedge clk);
        collect(-1);
        check("restart_first_edge", first_e, K);
        check("restart_idx0", cap_idx[0], 0);
        check("restart_zeta0", cap_z[0], 1);
        check("restart_count", cap_n, N);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
